// File: rtl/maj_seq_eval.sv
// Time-multiplexed MAJ3 network evaluator: a loaded program of majority nodes
// is run one node per cycle on each accepted 7-bit input vector.
module maj_seq_eval #(
  parameter int NUM_IN    = 7,
  parameter int MAX_NODES = 16,
  parameter int SEL_W     = 5,
  parameter int LEN_W     = 5,
  localparam int AW       = $clog2(MAX_NODES),
  localparam int OP_W     = 1 + SEL_W,
  localparam int NODE_W   = 3 * OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_data,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_out_inv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NODE_W-1:0]        prog_q [MAX_NODES];
  logic [MAX_NODES-1:0]     node_q;
  logic [NUM_IN-1:0]        x_q;
  logic [LEN_W-1:0]         len_q;
  logic                     inv_q;
  logic                     err_q;
  logic [AW-1:0]            j_q;
  logic                     y_q;

  logic                     idle, accept, last, bad_any, maj;
  logic [LEN_W-1:0]         len_wr, len_eff;
  logic                     inv_eff;
  logic [NODE_W-1:0]        cur;
  logic [2:0]               opnd, opbad;

  assign idle   = (state_q == IDLE);
  assign accept = idle && in_valid;
  assign len_wr = (cfg_len > LEN_W'(MAX_NODES)) ? LEN_W'(MAX_NODES) : cfg_len;
  // A length write coinciding with acceptance must steer this very vector.
  assign len_eff = (idle && cfg_len_we) ? len_wr : len_q;
  assign inv_eff = (idle && cfg_len_we) ? cfg_out_inv : inv_q;
  assign cur     = prog_q[j_q];
  assign last    = (LEN_W'(j_q) + 1'b1) == len_q;

  // Operand fetch: only strictly earlier nodes are legal; anything else reads 0 and flags err.
  always_comb begin
    opnd  = '0;
    opbad = '0;
    for (int o = 0; o < 3; o++) begin
      logic [SEL_W-1:0] sel;
      logic             v;
      sel = cur[o*OP_W +: SEL_W];
      v   = 1'b0;
      for (int i = 0; i < NUM_IN; i++)
        if (int'(sel) == i + 1) v = x_q[i];
      for (int k = 0; k < MAX_NODES; k++)
        if (int'(sel) == k + 1 + NUM_IN) begin
          if (k < int'(j_q)) v = node_q[k];
          else               opbad[o] = 1'b1;
        end
      if (int'(sel) >= 1 + NUM_IN + MAX_NODES) opbad[o] = 1'b1;
      opnd[o] = v ^ cur[o*OP_W + SEL_W];
    end
  end

  assign maj     = (opnd[2] & opnd[1]) | (opnd[2] & opnd[0]) | (opnd[1] & opnd[0]);
  assign bad_any = |opbad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (len_eff == '0) ? DONE : EVAL;
      EVAL:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = idle;
    out_valid = (state_q == DONE);
    busy      = !idle;
    out_y     = y_q;
    err       = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < MAX_NODES; n++) prog_q[n] <= '0;
      node_q <= '0;
      x_q    <= '0;
      len_q  <= '0;
      inv_q  <= 1'b0;
      err_q  <= 1'b0;
      j_q    <= '0;
      y_q    <= 1'b0;
    end else begin
      if (idle && cfg_we) prog_q[cfg_addr] <= cfg_data;
      if (idle && cfg_len_we) begin
        len_q <= len_wr;
        inv_q <= cfg_out_inv;
      end
      if (accept) begin
        x_q <= in_x;
        j_q <= '0;
        if (len_eff == '0) y_q <= inv_eff;
      end
      if (state_q == EVAL) begin
        node_q[j_q] <= maj;
        if (bad_any) err_q <= 1'b1;
        if (last) y_q <= maj ^ inv_q;
        else      j_q <= j_q + 1'b1;
      end
    end
  end

endmodule
